// File: rtl/custom_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : custom_axi_pkg
// Purpose  : Shared response codes, FSM state types and register stride for
//            the custom AXI-Lite register interface.
// Revision : 1.0 - initial release
// ============================================================================
package custom_axi_pkg;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam int unsigned REG_STRIDE  = 4;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_EXEC = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/custom_axi_regif_rd.sv
`default_nettype none
// ============================================================================
// Module   : custom_axi_regif_rd
// Purpose  : AXI-Lite read channel: decodes AR, waits on the IP's per-register
//            valid with a bounded timeout, and holds R until accepted.
// Revision : 1.0 - initial release
// ============================================================================
module custom_axi_regif_rd
   import custom_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_REGS   = 3,
   parameter int TIMEOUT    = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [ADDR_WIDTH-1:0]    araddr_i,
   input  logic                     arvalid_i,
   output logic                     arready_o,
   output logic [31:0]              rdata_o,
   output logic [1:0]               rresp_o,
   output logic                     rvalid_o,
   input  logic                     rready_i,
   input  logic [NUM_REGS*32-1:0]   ip2reg_data_i,
   input  logic [NUM_REGS-1:0]      ip2reg_valid_i
);

   localparam int c_lsb   = $clog2(REG_STRIDE);
   localparam int c_idx_w = ADDR_WIDTH - c_lsb;
   localparam int c_cnt_w = $clog2(TIMEOUT + 1);

   rd_state_e            state_q, state_d;
   logic [c_idx_w-1:0]   idx_q, idx_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic                 arready_q, arready_d;
   logic                 rvalid_q, rvalid_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [1:0]           rresp_q, rresp_d;

   logic [c_idx_w-1:0]   w_ar_idx;
   logic                 w_ar_in_range;
   logic                 w_sel_valid;
   logic [31:0]          w_sel_data;
   logic                 w_unused_ar_lsbs;

   assign w_ar_idx         = araddr_i[ADDR_WIDTH-1:c_lsb];
   assign w_ar_in_range    = (w_ar_idx < c_idx_w'(NUM_REGS));
   assign w_unused_ar_lsbs = ^araddr_i[c_lsb-1:0];

   // Pick the valid/data pair of the register captured at AR time.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx_q == c_idx_w'(i)) begin
            w_sel_valid = ip2reg_valid_i[i];
            w_sel_data  = ip2reg_data_i[32*i +: 32];
         end
      end
   end

   // Read FSM next-state and registered-output values.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      unique case (state_q)
         R_IDLE: begin
            if (arvalid_i && arready_q) begin
               if (w_ar_in_range) begin
                  state_d = R_WAIT;
                  idx_d   = w_ar_idx;
                  cnt_d   = '0;
               end else begin
                  state_d  = R_DATA;
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  rresp_d  = RESP_SLVERR;
               end
            end
         end
         R_WAIT: begin
            // Valid wins even on the final allowed cycle.
            if (w_sel_valid) begin
               state_d  = R_DATA;
               rvalid_d = 1'b1;
               rdata_d  = w_sel_data;
               rresp_d  = RESP_OKAY;
            end else if (cnt_q == c_cnt_w'(TIMEOUT)) begin
               state_d  = R_DATA;
               rvalid_d = 1'b1;
               rdata_d  = '0;
               rresp_d  = RESP_SLVERR;
            end else begin
               cnt_d = cnt_q + c_cnt_w'(1);
            end
         end
         R_DATA: begin
            if (rready_i) begin
               state_d  = R_IDLE;
               rvalid_d = 1'b0;
            end
         end
         default: state_d = R_IDLE;
      endcase
      arready_d = (state_d == R_IDLE);
   end

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= R_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign arready_o = arready_q;
   assign rvalid_o  = rvalid_q;
   assign rdata_o   = rdata_q;
   assign rresp_o   = rresp_q;

endmodule
`default_nettype wire

// File: rtl/custom_axi_regif.sv
`default_nettype none
// ============================================================================
// Module   : custom_axi_regif
// Purpose  : AXI4-Lite responder for the custom IP register block. Writes are
//            byte-merged into shadow copies and strobed to the IP; reads are
//            served from the IP return path by custom_axi_regif_rd.
// Revision : 1.0 - initial release
// ============================================================================
module custom_axi_regif
   import custom_axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_REGS   = 3,
   parameter int TIMEOUT    = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [ADDR_WIDTH-1:0]    awaddr_i,
   input  logic                     awvalid_i,
   output logic                     awready_o,
   input  logic [31:0]              wdata_i,
   input  logic [3:0]               wstrb_i,
   input  logic                     wvalid_i,
   output logic                     wready_o,
   output logic [1:0]               bresp_o,
   output logic                     bvalid_o,
   input  logic                     bready_i,
   input  logic [ADDR_WIDTH-1:0]    araddr_i,
   input  logic                     arvalid_i,
   output logic                     arready_o,
   output logic [31:0]              rdata_o,
   output logic [1:0]               rresp_o,
   output logic                     rvalid_o,
   input  logic                     rready_i,
   output logic [NUM_REGS*32-1:0]   reg2ip_data_o,
   output logic [NUM_REGS-1:0]      reg2ip_en_o,
   input  logic [NUM_REGS*32-1:0]   ip2reg_data_i,
   input  logic [NUM_REGS-1:0]      ip2reg_valid_i
);

   localparam int c_lsb   = $clog2(REG_STRIDE);
   localparam int c_idx_w = ADDR_WIDTH - c_lsb;

   wr_state_e              state_q, state_d;
   logic                   aw_held_q, aw_held_d;
   logic                   w_held_q, w_held_d;
   logic [c_idx_w-1:0]     awidx_q, awidx_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic                   awready_q, awready_d;
   logic                   wready_q, wready_d;
   logic                   bvalid_q, bvalid_d;
   logic [1:0]             bresp_q, bresp_d;
   logic [NUM_REGS-1:0]    en_q, en_d;
   // The shadow copies double as the reg2ip data outputs: they are updated
   // together and always hold the same value.
   logic [NUM_REGS*32-1:0] shadow_q, shadow_d;
   logic                   w_unused_aw_lsbs;

   assign w_unused_aw_lsbs = ^awaddr_i[c_lsb-1:0];

   // Write FSM: latch AW/W independently, merge and strobe, then respond.
   always_comb begin
      state_d   = state_q;
      aw_held_d = aw_held_q;
      w_held_d  = w_held_q;
      awidx_d   = awidx_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      shadow_d  = shadow_q;
      en_d      = '0;
      unique case (state_q)
         W_IDLE: begin
            if (awvalid_i && awready_q) begin
               aw_held_d = 1'b1;
               awidx_d   = awaddr_i[ADDR_WIDTH-1:c_lsb];
            end
            if (wvalid_i && wready_q) begin
               w_held_d = 1'b1;
               wdata_d  = wdata_i;
               wstrb_d  = wstrb_i;
            end
            // Merge is computed here so the strobe is registered and
            // visible during the W_EXEC cycle.
            if (aw_held_d && w_held_d) begin
               state_d = W_EXEC;
               bresp_d = RESP_SLVERR;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (awidx_d == c_idx_w'(i)) begin
                     for (int b = 0; b < 4; b++) begin
                        if (wstrb_d[b]) begin
                           shadow_d[32*i + 8*b +: 8] = wdata_d[8*b +: 8];
                        end
                     end
                     en_d[i] = 1'b1;
                     bresp_d = RESP_OKAY;
                  end
               end
            end
         end
         W_EXEC: begin
            state_d  = W_RESP;
            bvalid_d = 1'b1;
         end
         W_RESP: begin
            if (bready_i) begin
               state_d   = W_IDLE;
               bvalid_d  = 1'b0;
               aw_held_d = 1'b0;
               w_held_d  = 1'b0;
            end
         end
         default: state_d = W_IDLE;
      endcase
      awready_d = (state_d == W_IDLE) && !aw_held_d;
      wready_d  = (state_d == W_IDLE) && !w_held_d;
   end

   // Write-path registers; reset discards any latched request or response.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= W_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         awidx_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         en_q      <= '0;
         shadow_q  <= '0;
      end else begin
         state_q   <= state_d;
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         awidx_q   <= awidx_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         en_q      <= en_d;
         shadow_q  <= shadow_d;
      end
   end

   assign awready_o     = awready_q;
   assign wready_o      = wready_q;
   assign bvalid_o      = bvalid_q;
   assign bresp_o       = bresp_q;
   assign reg2ip_en_o   = en_q;
   assign reg2ip_data_o = shadow_q;

   custom_axi_regif_rd #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .TIMEOUT    (TIMEOUT)
   ) u_rd (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .araddr_i       (araddr_i),
      .arvalid_i      (arvalid_i),
      .arready_o      (arready_o),
      .rdata_o        (rdata_o),
      .rresp_o        (rresp_o),
      .rvalid_o       (rvalid_o),
      .rready_i       (rready_i),
      .ip2reg_data_i  (ip2reg_data_i),
      .ip2reg_valid_i (ip2reg_valid_i)
   );

endmodule
`default_nettype wire

// File: tb/tb_custom_axi_regif.sv
`default_nettype none
// ============================================================================
// Module   : tb_custom_axi_regif
// Purpose  : Directed self-checking bench for custom_axi_regif with a
//            timestamp-based transaction model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_custom_axi_regif;

   localparam int         ADDR_WIDTH = 12;
   localparam int         NUM_REGS   = 3;
   localparam int         TIMEOUT    = 16;
   localparam int         MAXW       = 60;
   localparam logic [1:0] OKAY       = 2'b00;
   localparam logic [1:0] SLVERR     = 2'b10;

   logic                   clk = 1'b0;
   logic                   rst_i = 1'b1;
   logic [ADDR_WIDTH-1:0]  awaddr_i = '0;
   logic                   awvalid_i = 1'b0;
   logic                   awready_o;
   logic [31:0]            wdata_i = '0;
   logic [3:0]             wstrb_i = '0;
   logic                   wvalid_i = 1'b0;
   logic                   wready_o;
   logic [1:0]             bresp_o;
   logic                   bvalid_o;
   logic                   bready_i = 1'b1;
   logic [ADDR_WIDTH-1:0]  araddr_i = '0;
   logic                   arvalid_i = 1'b0;
   logic                   arready_o;
   logic [31:0]            rdata_o;
   logic [1:0]             rresp_o;
   logic                   rvalid_o;
   logic                   rready_i = 1'b1;
   logic [NUM_REGS*32-1:0] reg2ip_data_o;
   logic [NUM_REGS-1:0]    reg2ip_en_o;
   logic [NUM_REGS*32-1:0] ip2reg_data_i = '0;
   logic [NUM_REGS-1:0]    ip2reg_valid_i = '0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   custom_axi_regif #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .awaddr_i       (awaddr_i),
      .awvalid_i      (awvalid_i),
      .awready_o      (awready_o),
      .wdata_i        (wdata_i),
      .wstrb_i        (wstrb_i),
      .wvalid_i       (wvalid_i),
      .wready_o       (wready_o),
      .bresp_o        (bresp_o),
      .bvalid_o       (bvalid_o),
      .bready_i       (bready_i),
      .araddr_i       (araddr_i),
      .arvalid_i      (arvalid_i),
      .arready_o      (arready_o),
      .rdata_o        (rdata_o),
      .rresp_o        (rresp_o),
      .rvalid_o       (rvalid_o),
      .rready_i       (rready_i),
      .reg2ip_data_o  (reg2ip_data_o),
      .reg2ip_en_o    (reg2ip_en_o),
      .ip2reg_data_i  (ip2reg_data_i),
      .ip2reg_valid_i (ip2reg_valid_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: no handshake within %0d cycles, expected one", name, MAXW);
   endtask

   // ---------------------------------------------------------------------
   // Transaction model: tracks accepted requests by cycle stamp and derives
   // when each response must appear from the documented latencies.
   // ---------------------------------------------------------------------
   int          mcyc = 0;
   bit          m_aw_got = 0, m_w_got = 0, m_wbusy = 0, m_rbusy = 0, m_rwait = 0;
   int          m_wlast = 0, m_ar = 0, m_ridx = 0;
   logic [11:0] m_awaddr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   logic [31:0] m_shadow [NUM_REGS];
   logic        e_awready = 0, e_wready = 0, e_bvalid = 0, e_arready = 0, e_rvalid = 0;
   logic [1:0]  e_bresp = 0, e_rresp = 0;
   logic [31:0] e_rdata = 0;
   logic [NUM_REGS-1:0] e_en = '0;

   task automatic model_reset();
      m_aw_got = 0; m_w_got = 0; m_wbusy = 0; m_rbusy = 0; m_rwait = 0;
      for (int i = 0; i < NUM_REGS; i++) m_shadow[i] = '0;
      e_awready = 0; e_wready = 0; e_bvalid = 0; e_arready = 0; e_rvalid = 0;
      e_bresp = 0; e_rresp = 0; e_rdata = 0; e_en = '0;
   endtask

   initial model_reset();

   always @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         model_reset();
      end else begin
         int prev;
         int widx;
         prev = mcyc;
         mcyc = mcyc + 1;
         // write side: inputs and expectations below belong to cycle prev
         if (e_bvalid && bready_i) begin
            m_wbusy = 0; m_aw_got = 0; m_w_got = 0;
         end
         if (awvalid_i && e_awready) begin m_aw_got = 1; m_awaddr = awaddr_i; end
         if (wvalid_i && e_wready) begin m_w_got = 1; m_wdata = wdata_i; m_wstrb = wstrb_i; end
         if (!m_wbusy && m_aw_got && m_w_got) begin m_wbusy = 1; m_wlast = prev; end
         e_en = '0;
         if (m_wbusy && mcyc == m_wlast + 1) begin
            widx = int'(m_awaddr >> 2);
            if (widx < NUM_REGS) begin
               for (int b = 0; b < 4; b++)
                  if (m_wstrb[b]) m_shadow[widx][8*b +: 8] = m_wdata[8*b +: 8];
               e_en[widx] = 1'b1;
               e_bresp = OKAY;
            end else begin
               e_bresp = SLVERR;
            end
         end
         e_bvalid  = m_wbusy && (mcyc >= m_wlast + 2);
         e_awready = !m_wbusy && !m_aw_got;
         e_wready  = !m_wbusy && !m_w_got;
         // read side
         if (e_rvalid && rready_i) begin m_rbusy = 0; e_rvalid = 0; end
         if (arvalid_i && e_arready) begin
            m_rbusy = 1;
            m_ridx  = int'(araddr_i >> 2);
            if (m_ridx < NUM_REGS) begin
               m_rwait = 1; m_ar = prev;
            end else begin
               e_rvalid = 1; e_rdata = 0; e_rresp = SLVERR;
            end
         end else if (m_rwait && prev >= m_ar + 1) begin
            if (ip2reg_valid_i[m_ridx]) begin
               m_rwait = 0; e_rvalid = 1; e_rresp = OKAY;
               e_rdata = ip2reg_data_i[32*m_ridx +: 32];
            end else if (prev - (m_ar + 1) == TIMEOUT) begin
               m_rwait = 0; e_rvalid = 1; e_rdata = 0; e_rresp = SLVERR;
            end
         end
         e_arready = !m_rbusy;
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin
      chk("awready", awready_o, e_awready);
      chk("wready", wready_o, e_wready);
      chk("bvalid", bvalid_o, e_bvalid);
      chk("arready", arready_o, e_arready);
      chk("rvalid", rvalid_o, e_rvalid);
      chk("reg2ip_en", reg2ip_en_o, e_en);
      if (e_bvalid) chk("bresp", bresp_o, e_bresp);
      if (e_rvalid) begin
         chk("rdata", rdata_o, e_rdata);
         chk("rresp", rresp_o, e_rresp);
      end
      for (int i = 0; i < NUM_REGS; i++)
         chk("reg2ip_data", reg2ip_data_o[32*i +: 32], m_shadow[i]);
   end

   // Strobe monitor used by the literal per-write checks.
   int                  en_total = 0;
   logic [NUM_REGS-1:0] en_last = '0;
   always @(negedge clk) begin
      if (reg2ip_en_o != '0) begin
         en_total++;
         en_last = reg2ip_en_o;
      end
   end

   task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input bit hold_b, output logic [1:0] resp);
      bit aw_on, aw_done, w_done, hs_aw, hs_w, got_b;
      int n;
      aw_on = 0; aw_done = 0; w_done = 0; got_b = 0; n = 0; resp = 2'b11;
      bready_i = !hold_b;
      wvalid_i = 1; wdata_i = d; wstrb_i = s;
      while (!(aw_done && w_done) && n < MAXW) begin
         if (!aw_on && !aw_done && n >= w_lead) begin awvalid_i = 1; awaddr_i = a; aw_on = 1; end
         @(negedge clk);
         hs_aw = awvalid_i && awready_o;
         hs_w  = wvalid_i && wready_o;
         @(posedge clk); #1;
         if (hs_aw) begin awvalid_i = 0; aw_on = 0; aw_done = 1; end
         if (hs_w)  begin wvalid_i = 0; w_done = 1; end
         n++;
      end
      if (!(aw_done && w_done)) begin
         wait_fail("write_aw_w");
         awvalid_i = 0; wvalid_i = 0;
      end else begin
         n = 0;
         while (!got_b && n < MAXW) begin
            @(negedge clk);
            if (bvalid_o) begin got_b = 1; resp = bresp_o; end
            else begin @(posedge clk); #1; n++; end
         end
         if (!got_b) wait_fail("write_b");
         else if (!hold_b) begin @(posedge clk); #1; end
      end
   endtask

   task automatic axi_read(input logic [11:0] a, input int hold,
                           output logic [31:0] d, output logic [1:0] r, output int lat);
      int  t_ar, n;
      bit  seen;
      t_ar = -1; n = 0; seen = 0; lat = -1; d = 32'hFFFF_FFFF; r = 2'b11;
      rready_i = (hold == 0);
      arvalid_i = 1; araddr_i = a;
      while (t_ar < 0 && n < MAXW) begin
         @(negedge clk);
         if (arready_o) t_ar = cyc;
         @(posedge clk); #1;
         n++;
      end
      arvalid_i = 0;
      if (t_ar < 0) begin
         wait_fail("read_ar");
      end else begin
         n = 0;
         while (!seen && n < MAXW) begin
            @(negedge clk);
            if (rvalid_o) begin seen = 1; lat = cyc - t_ar; d = rdata_o; r = rresp_o; end
            else begin @(posedge clk); #1; n++; end
         end
         if (!seen) begin
            wait_fail("read_r");
         end else begin
            for (int k = 0; k < hold; k++) begin
               @(posedge clk); #1;
               @(negedge clk);
               chk("r_hold_valid", rvalid_o, 1);
               chk("r_hold_data", rdata_o, d);
               chk("r_hold_resp", rresp_o, r);
            end
            @(posedge clk); #1;
            if (hold > 0) begin
               rready_i = 1;
               @(posedge clk); #1;
            end
         end
      end
      rready_i = 1;
   endtask

   initial begin : main
      logic [1:0]  resp;
      logic [31:0] rd;
      int          lat, base, n;
      bit          found;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_awready", awready_o, 0);
      chk("rst_arready", arready_o, 0);
      chk("rst_bvalid", bvalid_o, 0);
      chk("rst_rvalid", rvalid_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_reg2ip_en", reg2ip_en_o, 0);
      rst_i = 0;
      @(posedge clk); #1;
      chk("post_rst_awready", awready_o, 1);
      chk("post_rst_arready", arready_o, 1);

      // full write, AW and W together
      base = en_total;
      axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
      chk("w1_bresp", resp, OKAY);
      chk("w1_pulses", en_total - base, 1);
      chk("w1_en", en_last, 3'b010);
      chk("w1_slice1", reg2ip_data_o[63:32], 32'hDEAD_BEEF);

      // W two cycles ahead of AW, low byte only
      base = en_total;
      axi_write(12'h004, 32'h0000_00AA, 4'h1, 2, 0, resp);
      chk("w2_bresp", resp, OKAY);
      chk("w2_pulses", en_total - base, 1);
      chk("w2_slice1", reg2ip_data_o[63:32], 32'hDEAD_BEAA);

      // zero strobe in range still pulses
      base = en_total;
      axi_write(12'h008, 32'hFFFF_FFFF, 4'h0, 0, 0, resp);
      chk("w3_bresp", resp, OKAY);
      chk("w3_en", en_last, 3'b100);
      chk("w3_pulses", en_total - base, 1);
      chk("w3_slice2", reg2ip_data_o[95:64], 32'h0);

      // out-of-range write and read
      base = en_total;
      axi_write(12'h00C, 32'h5555_5555, 4'hF, 0, 0, resp);
      chk("w4_bresp", resp, SLVERR);
      chk("w4_pulses", en_total - base, 0);
      axi_read(12'h010, 0, rd, resp, lat);
      chk("r1_rdata", rd, 0);
      chk("r1_rresp", resp, SLVERR);
      chk("r1_latency", lat, 1);

      // in-range read with valid, R held off for 5 cycles
      ip2reg_data_i  = {32'h1234_5678, 32'hDEAD_BEAA, 32'h0};
      ip2reg_valid_i = 3'b100;
      axi_read(12'h008, 5, rd, resp, lat);
      chk("r2_rdata", rd, 32'h1234_5678);
      chk("r2_rresp", resp, OKAY);
      chk("r2_latency", lat, 2);

      // timeout on register 0
      ip2reg_data_i  = {32'h1234_5678, 32'hDEAD_BEAA, 32'hBAD0_BAD0};
      ip2reg_valid_i = 3'b000;
      axi_read(12'h000, 0, rd, resp, lat);
      chk("r3_rdata", rd, 0);
      chk("r3_rresp", resp, SLVERR);
      chk("r3_latency", lat, TIMEOUT + 2);

      // reset while the write response is pending
      axi_write(12'h000, 32'h1122_3344, 4'hF, 0, 1, resp);
      chk("w5_bresp", resp, OKAY);
      chk("w5_slice0_before_rst", reg2ip_data_o[31:0], 32'h1122_3344);
      #2 rst_i = 1;
      #1;
      chk("w5_bvalid_rst", bvalid_o, 0);
      chk("w5_slice0_rst", reg2ip_data_o[31:0], 0);
      chk("w5_bresp_rst", bresp_o, 0);
      repeat (2) @(posedge clk);
      #1 rst_i = 0;
      bready_i = 1;

      // reset while a read waits on the IP
      ip2reg_valid_i = 3'b000;
      arvalid_i = 1; araddr_i = 12'h004; found = 0; n = 0;
      while (!found && n < MAXW) begin
         @(negedge clk);
         if (arready_o) found = 1;
         @(posedge clk); #1;
         n++;
      end
      arvalid_i = 0;
      if (!found) wait_fail("rst_read_ar");
      repeat (3) @(posedge clk);
      #2 rst_i = 1;
      #1;
      chk("r4_rvalid_rst", rvalid_o, 0);
      chk("r4_arready_rst", arready_o, 0);
      chk("r4_rdata_rst", rdata_o, 0);
      chk("r4_rresp_rst", rresp_o, 0);
      repeat (2) @(posedge clk);
      #1 rst_i = 0;
      @(posedge clk); #1;

      // normal write after reset, shadows cleared
      base = en_total;
      axi_write(12'h008, 32'hCAFE_F00D, 4'hF, 0, 0, resp);
      chk("w6_bresp", resp, OKAY);
      chk("w6_en", en_last, 3'b100);
      chk("w6_pulses", en_total - base, 1);
      chk("w6_slice2", reg2ip_data_o[95:64], 32'hCAFE_F00D);
      chk("w6_slice0", reg2ip_data_o[31:0], 0);
      chk("w6_slice1", reg2ip_data_o[63:32], 0);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
